poved_decoder_scan: RTL

Parametrised registered successor to the combinational 3-to-6 behavioural decoder. It drives a one-hot select bus, with programmable width and output count. It has two modes:
- Direct: registers a decode of an input address.
- Scan: an internal dwell counter and index counter cycle the one-hot output through every channel.

It is used for digit/row select and channel strobing in the education designs.

---
 rtl/poved_decoder_scan_if.sv | 25 ++
 rtl/poved_decoder_scan.sv | 103 ++++++++++
 2 files changed

// File: rtl/poved_decoder_scan_if.sv
// Select-bus interface for poved_decoder_scan: control/address inputs and
// the registered select outputs, with master (driver) and slave (decoder) views.
interface poved_decoder_scan_if #(
    parameter int IN_W  = 3,
    parameter int OUT_N = 6
);
    logic             en;
    logic             mode;
    logic [IN_W-1:0]  a;
    logic             a_vld;
    logic [OUT_N-1:0] b;
    logic [IN_W-1:0]  idx;
    logic             err;
    logic             step;

    modport master (
        output en, mode, a, a_vld,
        input  b, idx, err, step
    );

    modport slave (
        input  en, mode, a, a_vld,
        output b, idx, err, step
    );
endinterface

// File: rtl/poved_decoder_scan.sv
// Registered one-hot (or one-cold) select decoder with a direct address-load
// mode and an automatic scan mode that walks every channel with a fixed dwell.
module poved_decoder_scan #(
    parameter int IN_W       = 3,
    parameter int OUT_N      = 6,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    poved_decoder_scan_if.slave  dec_if
);

    localparam int               DW         = $clog2(DWELL) + 1;
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [IN_W-1:0]  IDX_LAST   = IN_W'(OUT_N - 1);
    localparam logic [IN_W:0]    OUT_N_EXT  = (IN_W + 1)'(OUT_N);
    localparam logic [OUT_N-1:0] IDLE       = {OUT_N{ACTIVE_LOW}};

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [OUT_N-1:0] sel_q, sel_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic             err_q, err_d;
    logic             step_q, step_d;
    logic [DW-1:0]    dwell_q, dwell_d;

    // Select pattern for an in-range index, already in output polarity.
    function automatic logic [OUT_N-1:0] selectLine(input logic [IN_W-1:0] i);
        logic [OUT_N-1:0] oneHot;
        oneHot = OUT_N'(1) << i;
        return ACTIVE_LOW ? ~oneHot : oneHot;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_DIRECT;
            sel_q   <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            step_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

    // Scan entry restarts at channel 0 with a fresh dwell; a direct load
    // outside the decoded range blanks the bus but still records the address.
    always_comb begin
        mode_d  = mode_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        err_d   = err_q;
        step_d  = 1'b0;
        dwell_d = dwell_q;

        if (dec_if.en) begin
            mode_d = mode_e'(dec_if.mode);
            if (dec_if.mode) begin
                err_d = 1'b0;
                if (mode_q == MODE_DIRECT) begin
                    idx_d   = '0;
                    sel_d   = selectLine('0);
                    dwell_d = '0;
                    step_d  = 1'b1;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    sel_d   = selectLine(idx_d);
                    step_d  = 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end else if (dec_if.a_vld) begin
                idx_d  = dec_if.a;
                step_d = 1'b1;
                if ({1'b0, dec_if.a} >= OUT_N_EXT) begin
                    sel_d = IDLE;
                    err_d = 1'b1;
                end else begin
                    sel_d = selectLine(dec_if.a);
                    err_d = 1'b0;
                end
            end
        end
    end

    assign dec_if.b    = sel_q;
    assign dec_if.idx  = idx_q;
    assign dec_if.err  = err_q;
    assign dec_if.step = step_q;

endmodule
